// File: rtl/crc_encode_serial.sv
// Bit-serial CRC encoder: one data bit per clock, MSB first, codeword {data, crc}.
// Optional build macro CRC_ERR_INJECT_EN adds a single-bit error injection port pair.
//
// state | meaning
// IDLE  | ready for a new data word
// SHIFT | dividing the latched word, one bit per cycle (N cycles)
// DONE  | codeword presented, waiting for out_ready
module crc_encode_serial #(
    parameter int            N   = 16,
    parameter int            R   = 7,
    parameter logic [R-1:0]  DIV = 7'b1111011
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 in_data,
    input  logic                         in_valid,
`ifdef CRC_ERR_INJECT_EN
    input  logic                         inj_en,
    input  logic [$clog2(N+R-1)-1:0]     inj_pos,
`endif
    output logic                         in_ready,
    output logic [N+R-2:0]               out_stream,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int W  = N + R - 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    initial begin
        if (R < 3)
            $fatal(1, "crc_encode_serial: R must be at least 3");
        if (DIV[R-1] !== 1'b1)
            $fatal(1, "crc_encode_serial: DIV top bit must be 1");
    end

    state_t         state_q, state_d;
    logic [N-1:0]   data_q, data_d;
    logic [R-2:0]   rem_q, rem_d, rem_step;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ov_q, ov_d;
    logic [W-1:0]   os_q, os_d;
    logic [W-1:0]   flip;
    logic           fb;

`ifdef CRC_ERR_INJECT_EN
    logic           inj_en_q, inj_en_d;
    logic [PW-1:0]  inj_pos_q, inj_pos_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            os_q    <= '0;
`ifdef CRC_ERR_INJECT_EN
            inj_en_q  <= 1'b0;
            inj_pos_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            os_q    <= os_d;
`ifdef CRC_ERR_INJECT_EN
            inj_en_q  <= inj_en_d;
            inj_pos_q <= inj_pos_d;
`endif
        end
    end

    // Flip is applied to the finished codeword, so the CRC itself is computed clean.
    always_comb begin
        flip = '0;
`ifdef CRC_ERR_INJECT_EN
        if (inj_en_q && ({1'b0, inj_pos_q} < (PW+1)'(W)))
            flip = W'(1) << inj_pos_q;
`endif
    end

    always_comb begin
        fb       = rem_q[R-2] ^ data_q[cnt_q];
        rem_step = {rem_q[R-3:0], 1'b0} ^ (fb ? DIV[R-2:0] : '0);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        os_d    = os_q;
`ifdef CRC_ERR_INJECT_EN
        inj_en_d  = inj_en_q;
        inj_pos_d = inj_pos_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    rem_d   = '0;
                    cnt_d   = CW'(N - 1);
                    state_d = SHIFT;
`ifdef CRC_ERR_INJECT_EN
                    inj_en_d  = inj_en;
                    inj_pos_d = inj_pos;
`endif
                end
            end
            SHIFT: begin
                rem_d = rem_step;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    ov_d    = 1'b1;
                    os_d    = {data_q, rem_step} ^ flip;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ov_d    = 1'b0;
            end
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = ov_q;
    assign out_stream = os_q;

endmodule

// File: tb/tb_crc_encode_serial.sv
// Self-checking bench for crc_encode_serial against a long-division CRC model.
// Build with CRC_ERR_INJECT_EN defined to also exercise the injection ports.
module tb_crc_encode_serial;

    localparam int            N   = 16;
    localparam int            R   = 7;
    localparam int            W   = N + R - 1;
    localparam int            PW  = $clog2(W);
    localparam logic [R-1:0]  DIV = 7'b1111011;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   out_stream;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           inj_en = 1'b0;
    logic [PW-1:0]  inj_pos = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    crc_encode_serial #(.N(N), .R(R), .DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
`ifdef CRC_ERR_INJECT_EN
        .inj_en     (inj_en),
        .inj_pos    (inj_pos),
`endif
        .in_ready   (in_ready),
        .out_stream (out_stream),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Remainder of v over GF(2) by the divisor, by plain long division.
    function automatic logic [R-2:0] gf2_mod(input logic [63:0] v, input int top);
        logic [63:0] x;
        logic [63:0] d;
        x = v;
        d = 64'(DIV);
        for (int i = top; i >= R - 1; i--)
            if (x[i]) x = x ^ (d << (i - (R - 1)));
        return x[R-2:0];
    endfunction

    function automatic logic [W-1:0] ref_codeword(input logic [N-1:0] d);
        logic [63:0] shifted;
        shifted = 64'(d) << (R - 1);
        return {d, gf2_mod(shifted, W - 1)};
    endfunction

    function automatic logic [R-2:0] syndrome(input logic [W-1:0] cw);
        return gf2_mod(64'(cw), W - 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // bp < 0: random out_ready; bp >= 0: out_ready held low for bp DONE cycles.
    task automatic run_word(input logic [N-1:0] d, input int bp, input logic ie,
                            input logic [PW-1:0] ip, input logic [W-1:0] exp_cw,
                            input logic exp_err);
        int t;
        int lat;
        int ir_bad;
        int unstable;
        logic [W-1:0] got;
        logic hs;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        inj_en   = ie;
        inj_pos  = ip;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(t), 64'(0));
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'($urandom_range(0, 1));
        in_data  = N'($urandom);
        inj_en   = 1'($urandom_range(0, 1));
        inj_pos  = PW'($urandom);
        lat = 0;
        ir_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ir_bad++;
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(N));
        hs = 1'b0;
        t = 0;
        unstable = 0;
        got = out_stream;
        while (!hs && t < 200) begin
            if (out_stream !== exp_cw || !out_valid) unstable++;
            if (in_ready) ir_bad++;
            out_ready = (bp < 0) ? 1'($urandom_range(0, 1)) : (t >= bp);
            hs = out_ready;
            got = out_stream;
            @(negedge clk);
            t++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        inj_en    = 1'b0;
        chk("handshake", 64'(hs), 64'(1));
        chk("codeword", 64'(got), 64'(exp_cw));
        chk("data_field", 64'(got[W-1:R-1]), 64'(d));
        chk("checker_err", 64'(syndrome(got) != '0), 64'(exp_err));
        chk("held_stable", 64'(unstable), 64'(0));
        chk("in_ready_busy", 64'(ir_bad), 64'(0));
        if (bp >= 0) chk("bp_cycles", 64'(t), 64'(bp + 1));
        chk("idle_ov", 64'(out_valid), 64'(0));
        chk("idle_ir", 64'(in_ready), 64'(1));
    endtask

    initial begin
        logic [N-1:0] d;
        do_reset();
        @(negedge clk);
        chk("rst_ov", 64'(out_valid), 64'(0));
        chk("rst_ir", 64'(in_ready), 64'(1));
        chk("rst_os", 64'(out_stream), 64'(0));

        run_word(16'h0000, 0, 1'b0, '0, 22'h000000, 1'b0);
        run_word(16'h0001, 0, 1'b0, '0, 22'h00007B, 1'b0);
        run_word(16'h0002, 0, 1'b0, '0, 22'h00008D, 1'b0);
        run_word(16'hFFFF, 10, 1'b0, '0, ref_codeword(16'hFFFF), 1'b0);

        // Reset during the 5th SHIFT cycle discards the word.
        @(negedge clk);
        in_data  = 16'hA5A5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_ov", 64'(out_valid), 64'(0));
        chk("midrst_ir", 64'(in_ready), 64'(1));
        repeat (N + 4) begin
            @(negedge clk);
            if (out_valid) chk("midrst_spurious", 64'(out_valid), 64'(0));
        end
        run_word(16'h1234, -1, 1'b0, '0, ref_codeword(16'h1234), 1'b0);

`ifdef CRC_ERR_INJECT_EN
        run_word(16'h0001, 0, 1'b1, PW'(0), 22'h00007A, 1'b1);
        run_word(16'h0001, 0, 1'b1, PW'(22), 22'h00007B, 1'b0);
        for (int i = 0; i < 20; i++) begin
            logic [PW-1:0] p;
            d = N'($urandom);
            p = PW'($urandom_range(0, W - 1));
            run_word(d, -1, 1'b1, p, ref_codeword(d) ^ (W'(1) << p), 1'b1);
        end
`endif

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0:       d = '0;
                1:       d = '1;
                default: d = N'($urandom);
            endcase
            run_word(d, -1, 1'b0, '0, ref_codeword(d), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
